// File: rtl/in_mem_seq_if.sv
// rtl/in_mem_seq_if.sv - in_mem read port plus outgoing sample stream of the read sequencer
// Signals:
//   mem_addr / mem_rden : read request to in_mem (sequencer drives)
//   mem_q               : registered read data, valid on the ce cycle after mem_rden
//   sample / sample_valid / sample_ready : valid/ready sample stream to the datapath
// Modports: master = sequencer side, slave = memory/consumer side.
interface in_mem_seq_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output mem_addr, mem_rden, sample, sample_valid,
        input  mem_q, sample_ready
    );

    modport slave (
        input  mem_addr, mem_rden, sample, sample_valid,
        output mem_q, sample_ready
    );
endinterface

// File: rtl/in_mem_seq.sv
// rtl/in_mem_seq.sv - read sequencer streaming in_mem words through a 2-entry skid FIFO
// Purpose: on an accepted start, reads 'length' words from in_mem beginning at
//   base_addr (addresses wrap modulo 2**ADDR_W) and delivers them in order on a
//   valid/ready sample stream, with busy/done status.
// Ports:
//   clk, sclr          : clock, synchronous active-low reset
//   ce                 : clock enable; 0 freezes everything except reset
//   start, base_addr,
//   length             : run request, sampled only when accepted in IDLE
//   loop               : keep repeating the run while held (IN_SEQ_LOOP_EN only)
//   bus (master)       : mem_addr/mem_rden/mem_q and sample/sample_valid/sample_ready
//   busy, done         : run in progress / pulse on the final transfer of a pass
// Build option: define IN_SEQ_LOOP_EN to add the loop port and looping runs.
module in_mem_seq #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic              ce,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef IN_SEQ_LOOP_EN
    input  logic              loop,
`endif
    in_mem_seq_if.master      bus,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rd_rem_q, rd_rem_d;   // reads left in the current pass
    logic [LEN_W-1:0]  xf_rem_q, xf_rem_d;   // transfers left in the current pass
    logic              empty_run_q, empty_run_d;
    logic              pend_q, pend_d;       // mem_q holds a word not yet taken
    logic [1:0]        cnt_q, cnt_d;         // words held in f0/f1
    logic [DATA_W-1:0] f0_q, f0_d, f1_q, f1_d;

    logic              valid, pop, push, issue, loop_eff;
    logic [1:0]        occ;
    logic [ADDR_W-1:0] pass_base;
    logic [LEN_W-1:0]  pass_len;

`ifdef IN_SEQ_LOOP_EN
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;

    // Dropping loop at any point makes the pass being read the last one.
    assign loop_eff  = loop_q & loop;
    assign pass_base = base_q;
    assign pass_len  = len_q;
`else
    assign loop_eff  = 1'b0;
    assign pass_base = '0;
    assign pass_len  = '0;
`endif

    // The word sitting in mem_q counts as a FIFO slot: it is presented directly
    // when the FIFO is empty and is captured into the FIFO if not taken, so the
    // first sample appears one cycle after the first read and never moves.
    always_comb begin
        valid = (cnt_q != 2'd0) | pend_q;
        pop   = ce & valid & bus.sample_ready;
        occ   = cnt_q + {1'b0, pend_q} - {1'b0, pop};
        issue = ce & (state_q == RUN) & (occ < 2'd2);
        push  = ce & pend_q & ~(pop & (cnt_q == 2'd0));
    end

    assign bus.sample_valid = valid;
    assign bus.sample       = (cnt_q != 2'd0) ? f0_q : (pend_q ? bus.mem_q : '0);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_rden     = issue;
    assign busy             = (state_q == RUN) | (state_q == DRAIN);

    always_comb begin
        f0_d   = f0_q;
        f1_d   = f1_q;
        cnt_d  = cnt_q;
        pend_d = ce ? issue : pend_q;
        if (pop && (cnt_q != 2'd0)) begin
            f0_d  = f1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) begin
                f0_d = bus.mem_q;
            end else begin
                f1_d = bus.mem_q;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    // done marks the final transfer itself (busy still high); DONE is the
    // one-cycle turnaround that also carries the pulse of a zero-length run.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_rem_d    = rd_rem_q;
        xf_rem_d    = xf_rem_q;
        empty_run_d = empty_run_q;
        done        = 1'b0;
`ifdef IN_SEQ_LOOP_EN
        loop_d      = loop_q;
        base_d      = base_q;
        len_d       = len_q;
`endif
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d      = base_addr;
                        rd_rem_d    = length;
                        xf_rem_d    = length;
                        empty_run_d = (length == '0);
                        state_d     = (length == '0) ? DONE : RUN;
`ifdef IN_SEQ_LOOP_EN
                        loop_d      = loop;
                        base_d      = base_addr;
                        len_d       = length;
`endif
                    end
                end
                RUN, DRAIN: begin
                    if (issue) begin
                        addr_d   = addr_q + ADDR_W'(1);
                        rd_rem_d = rd_rem_q - LEN_W'(1);
                        if (rd_rem_q == LEN_W'(1)) begin
                            if (loop_eff) begin
                                addr_d   = pass_base;
                                rd_rem_d = pass_len;
                            end else begin
                                state_d = DRAIN;
                            end
                        end
                    end
                    if (pop) begin
                        if (xf_rem_q == LEN_W'(1)) begin
                            done     = 1'b1;
                            xf_rem_d = pass_len;
                        end else begin
                            xf_rem_d = xf_rem_q - LEN_W'(1);
                        end
                        if ((state_q == DRAIN) && ((cnt_q + {1'b0, pend_q}) == 2'd1)) begin
                            state_d = DONE;
                        end
                    end
`ifdef IN_SEQ_LOOP_EN
                    loop_d = loop_eff;
`endif
                end
                DONE: begin
                    done    = empty_run_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_rem_q    <= '0;
            xf_rem_q    <= '0;
            empty_run_q <= 1'b0;
            pend_q      <= 1'b0;
            cnt_q       <= 2'd0;
            f0_q        <= '0;
            f1_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_rem_q    <= rd_rem_d;
            xf_rem_q    <= xf_rem_d;
            empty_run_q <= empty_run_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            f0_q        <= f0_d;
            f1_q        <= f1_d;
        end
    end

`ifdef IN_SEQ_LOOP_EN
    always_ff @(posedge clk) begin
        if (!sclr) begin
            loop_q <= 1'b0;
            base_q <= '0;
            len_q  <= '0;
        end else begin
            loop_q <= loop_d;
            base_q <= base_d;
            len_q  <= len_d;
        end
    end
`endif

endmodule
